trig_router: RTL and testbench

// - Parametrised successor to the fixed 2:1 trigger mux and LED heartbeat counter in the CW305 top level.
// - Selects one of pSOURCES trigger inputs (M3 GPIO soft trigger, trace match triggers, ...).
// - Detects rising edges on the selected source and emits a delayed, width-programmable pulse on trig_out.
// - Also provides a capture-quiet heartbeat counter for led1 and a saturating trigger event counter.

---
 rtl/trig_router_if.sv | 40 ++++
 rtl/trig_router.sv | 239 +++++++++++++++++++++++
 tb/tb_trig_router.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_router_if.sv
`timescale 1ns/1ps
// Bus bundle for trig_router: trigger sources, configuration inputs and status outputs.
// The router side uses the slave modport; whoever drives configuration uses master.
interface trig_router_if #(
  parameter int pSOURCES     = 4,
  parameter int pSEL_WIDTH   = 2,
  parameter int pDELAY_WIDTH = 16,
  parameter int pWIDTH_WIDTH = 16,
  parameter int pCNT_WIDTH   = 16
);
  logic [pSOURCES-1:0]     I_sources;
  logic [pSEL_WIDTH-1:0]   I_src_sel;
  logic                    I_invert;
  logic [pDELAY_WIDTH-1:0] I_delay;
  logic [pWIDTH_WIDTH-1:0] I_pulse_width;
  logic [pDELAY_WIDTH-1:0] I_holdoff;
  logic                    I_arm;
  logic                    I_continuous;
  logic                    O_trig_out;
  logic                    O_trig_out_dbg;
  logic                    O_armed;
  logic                    O_busy;
  logic                    O_led_alive;
  logic [pCNT_WIDTH-1:0]   O_trig_count;
  logic [pCNT_WIDTH-1:0]   O_missed_count;

  modport master (
    output I_sources, I_src_sel, I_invert, I_delay, I_pulse_width, I_holdoff,
           I_arm, I_continuous,
    input  O_trig_out, O_trig_out_dbg, O_armed, O_busy, O_led_alive,
           O_trig_count, O_missed_count
  );

  modport slave (
    input  I_sources, I_src_sel, I_invert, I_delay, I_pulse_width, I_holdoff,
           I_arm, I_continuous,
    output O_trig_out, O_trig_out_dbg, O_armed, O_busy, O_led_alive,
           O_trig_count, O_missed_count
  );
endinterface

// File: rtl/trig_router.sv
`timescale 1ns/1ps
// Trigger router: source select, edge detect, delayed programmable pulse, heartbeat and event counters.
// Optional re-arm holdoff state is compiled in with the TRIG_HOLDOFF_EN macro.
module trig_router #(
  parameter int pSOURCES     = 4,
  parameter int pSEL_WIDTH   = 2,
  parameter int pDELAY_WIDTH = 16,
  parameter int pWIDTH_WIDTH = 16,
  parameter int pLED_WIDTH   = 23,
  parameter int pCNT_WIDTH   = 16
) (
  input  logic          ext_clock,
  input  logic          resetn,
  trig_router_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DELAY = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_LEVEL = 3'd3;
`ifdef TRIG_HOLDOFF_EN
  localparam logic [2:0] ST_HOLD  = 3'd4;
`endif

  localparam logic [pDELAY_WIDTH-1:0] D_ZERO = '0;
  localparam logic [pDELAY_WIDTH-1:0] D_ONE  = pDELAY_WIDTH'(1);
  localparam logic [pWIDTH_WIDTH-1:0] W_ZERO = '0;
  localparam logic [pWIDTH_WIDTH-1:0] W_ONE  = pWIDTH_WIDTH'(1);
  localparam logic [pCNT_WIDTH-1:0]   C_ONE  = pCNT_WIDTH'(1);
  localparam logic [pCNT_WIDTH-1:0]   C_MAX  = '1;
  localparam logic [pLED_WIDTH-1:0]   L_ONE  = pLED_WIDTH'(1);

  function automatic logic [pCNT_WIDTH-1:0] sat_inc(input logic [pCNT_WIDTH-1:0] v,
                                                    input logic en);
    if (en && (v != C_MAX)) begin
      sat_inc = v + C_ONE;
    end else begin
      sat_inc = v;
    end
  endfunction

  logic [2:0]              state_q, state_d;
  logic [pDELAY_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [pWIDTH_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                    src_prev_q;
  logic [pSEL_WIDTH-1:0]   sel_prev_q;
  logic                    inv_prev_q;
  logic                    trig_q, trig_d;
  logic                    trig_dbg_q;
  logic                    armed_q, armed_d;
  logic                    busy_q, busy_d;
  logic [pLED_WIDTH-1:0]   led_q, led_d;
  logic [pCNT_WIDTH-1:0]   trig_cnt_q, trig_cnt_d;
  logic [pCNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;
`ifdef TRIG_HOLDOFF_EN
  logic [pDELAY_WIDTH-1:0] hold_q, hold_d;
`else
  logic                    unused_holdoff_s;
`endif

  logic                    sel_src_s;
  logic                    src_s;
  logic                    reselect_s;
  logic                    edge_s;
  logic                    accept_s;
  logic                    missed_s;
  logic                    pulse_end_s;
  logic [2:0]              end_state_s;
  logic [pDELAY_WIDTH-1:0] end_dcnt_s;

  // Source multiplexer; out-of-range select indices never match and yield 0.
  always_comb begin
    sel_src_s = 1'b0;
    for (int i = 0; i < pSOURCES; i++) begin
      sel_src_s = sel_src_s | (bus.I_sources[i] & (bus.I_src_sel == pSEL_WIDTH'(i)));
    end
  end

  assign src_s      = sel_src_s ^ bus.I_invert;
  assign reselect_s = (bus.I_src_sel != sel_prev_q) | (bus.I_invert != inv_prev_q);
  assign edge_s     = src_s & ~src_prev_q & ~reselect_s;
  assign accept_s   = edge_s & armed_q & (state_q == ST_IDLE);
  assign missed_s   = edge_s & armed_q & (state_q != ST_IDLE);

`ifdef TRIG_HOLDOFF_EN
  assign end_state_s = (hold_q != D_ZERO) ? ST_HOLD : ST_IDLE;
  assign end_dcnt_s  = hold_q - D_ONE;
`else
  assign end_state_s      = ST_IDLE;
  assign end_dcnt_s       = dcnt_q;
  assign unused_holdoff_s = ^bus.I_holdoff;
`endif

  // Sequencer: wcnt holds the latched width while delaying, then counts the pulse down.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    wcnt_d      = wcnt_q;
    trig_d      = 1'b0;
    pulse_end_s = 1'b0;
`ifdef TRIG_HOLDOFF_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
`ifdef TRIG_HOLDOFF_EN
          hold_d = bus.I_holdoff;
`endif
          if (bus.I_pulse_width == W_ZERO) begin
            state_d = ST_LEVEL;
            trig_d  = src_s;
          end else if (bus.I_delay == D_ZERO) begin
            state_d = ST_PULSE;
            trig_d  = 1'b1;
            wcnt_d  = bus.I_pulse_width - W_ONE;
          end else begin
            state_d = ST_DELAY;
            dcnt_d  = bus.I_delay - D_ONE;
            wcnt_d  = bus.I_pulse_width;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (dcnt_q == D_ZERO) begin
          state_d = ST_PULSE;
          trig_d  = 1'b1;
          wcnt_d  = wcnt_q - W_ONE;
        end else begin
          dcnt_d = dcnt_q - D_ONE;
        end
      end
      ST_PULSE: begin
        if (wcnt_q == W_ZERO) begin
          pulse_end_s = 1'b1;
          state_d     = end_state_s;
          dcnt_d      = end_dcnt_s;
        end else begin
          wcnt_d = wcnt_q - W_ONE;
          trig_d = 1'b1;
        end
      end
      ST_LEVEL: begin
        if (src_s) begin
          trig_d = 1'b1;
        end else begin
          pulse_end_s = 1'b1;
          state_d     = end_state_s;
          dcnt_d      = end_dcnt_s;
        end
      end
`ifdef TRIG_HOLDOFF_EN
      ST_HOLD: begin
        if (dcnt_q == D_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q - D_ONE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arm strobe takes priority over the one-shot clear at pulse end.
  always_comb begin
    if (bus.I_arm) begin
      armed_d = 1'b1;
    end else if (pulse_end_s && !bus.I_continuous) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
  end

  // Heartbeat freezes while the trigger is high so the target stays quiet during capture.
  always_comb begin
    if (trig_q) begin
      led_d = led_q;
    end else begin
      led_d = led_q + L_ONE;
    end
    busy_d     = (state_d != ST_IDLE);
    trig_cnt_d = sat_inc(trig_cnt_q, pulse_end_s);
    miss_cnt_d = sat_inc(miss_cnt_q, missed_s);
  end

  // State and output registers.
  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      dcnt_q     <= '0;
      wcnt_q     <= '0;
      src_prev_q <= 1'b0;
      sel_prev_q <= '0;
      inv_prev_q <= 1'b0;
      trig_q     <= 1'b0;
      trig_dbg_q <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      led_q      <= '0;
      trig_cnt_q <= '0;
      miss_cnt_q <= '0;
`ifdef TRIG_HOLDOFF_EN
      hold_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      wcnt_q     <= wcnt_d;
      src_prev_q <= src_s;
      sel_prev_q <= bus.I_src_sel;
      inv_prev_q <= bus.I_invert;
      trig_q     <= trig_d;
      trig_dbg_q <= trig_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      led_q      <= led_d;
      trig_cnt_q <= trig_cnt_d;
      miss_cnt_q <= miss_cnt_d;
`ifdef TRIG_HOLDOFF_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign bus.O_trig_out     = trig_q;
  assign bus.O_trig_out_dbg = trig_dbg_q;
  assign bus.O_armed        = armed_q;
  assign bus.O_busy         = busy_q;
  assign bus.O_led_alive    = led_q[pLED_WIDTH-1];
  assign bus.O_trig_count   = trig_cnt_q;
  assign bus.O_missed_count = miss_cnt_q;

endmodule

// File: tb/tb_trig_router.sv
`timescale 1ns/1ps
// Directed bench for trig_router with a short heartbeat and 4-bit event counters.
// Build with +define+TRIG_HOLDOFF_EN to check the holdoff expectations instead of the default ones.
module tb_trig_router;

  logic        clk;
  logic        rst_n;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          first_led;
  logic [31:0] rec, rec2, rec3;

  trig_router_if #(.pCNT_WIDTH(4)) bus ();

  trig_router #(.pLED_WIDTH(4), .pCNT_WIDTH(4)) dut (
    .ext_clock (clk),
    .resetn    (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.I_sources     = 4'b0000;
    bus.I_src_sel     = 2'd0;
    bus.I_invert      = 1'b0;
    bus.I_delay       = 16'd0;
    bus.I_pulse_width = 16'd0;
    bus.I_holdoff     = 16'd0;
    bus.I_arm         = 1'b0;
    bus.I_continuous  = 1'b0;
    tick(2);
    chk("rst_trig",   32'(bus.O_trig_out),     32'd0);
    chk("rst_dbg",    32'(bus.O_trig_out_dbg), 32'd0);
    chk("rst_busy",   32'(bus.O_busy),         32'd0);
    chk("rst_armed",  32'(bus.O_armed),        32'd0);
    chk("rst_count",  32'(bus.O_trig_count),   32'd0);
    chk("rst_missed", 32'(bus.O_missed_count), 32'd0);
    chk("rst_led",    32'(bus.O_led_alive),    32'd0);

    // Heartbeat: 4-bit counter, MSB rises after 8 idle cycles and wraps after 16.
    rst_n = 1'b1;
    tick(7);
    chk("hb_cycle7", 32'(bus.O_led_alive), 32'd0);
    tick(1);
    chk("hb_cycle8", 32'(bus.O_led_alive), 32'd1);
    tick(8);
    chk("hb_wrap", 32'(bus.O_led_alive), 32'd0);

    // One-shot, delay 0, width 3.
    bus.I_src_sel     = 2'd1;
    bus.I_delay       = 16'd0;
    bus.I_pulse_width = 16'd3;
    bus.I_continuous  = 1'b0;
    tick(1);
    bus.I_arm = 1'b1;
    tick(1);
    bus.I_arm = 1'b0;
    chk("a_armed", 32'(bus.O_armed), 32'd1);
    bus.I_sources = 4'b0010;
    rec = '0; rec2 = '0; rec3 = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      rec[i]  = bus.O_trig_out;
      rec2[i] = bus.O_busy;
      rec3[i] = bus.O_trig_out_dbg;
    end
    chk("a_trig",      rec,  32'h07);
    chk("a_busy",      rec2, 32'h07);
    chk("a_dbg",       rec3, 32'h07);
    chk("a_count",     32'(bus.O_trig_count), 32'd1);
    chk("a_armed_clr", 32'(bus.O_armed),      32'd0);
    bus.I_sources = 4'b0000;

    // Continuous, delay 5, width 2; edges at 0 (pulse 6..7), 4 (missed), 20 (pulse 26..27).
    bus.I_continuous  = 1'b1;
    bus.I_delay       = 16'd5;
    bus.I_pulse_width = 16'd2;
    tick(1);
    bus.I_arm = 1'b1;
    tick(1);
    bus.I_arm = 1'b0;
    rec = '0;
    for (int c = 0; c < 29; c++) begin
      bus.I_sources = (c == 0 || c == 4 || c == 20) ? 4'b0010 : 4'b0000;
      tick(1);
      rec[c+1] = bus.O_trig_out;
    end
    chk("b_trig",   rec, 32'h0C0000C0);
    chk("b_missed", 32'(bus.O_missed_count), 32'd1);
    chk("b_count",  32'(bus.O_trig_count),   32'd3);
    chk("b_armed",  32'(bus.O_armed),        32'd1);

    // Level mode with inversion: source low for 7 cycles, delay ignored.
    bus.I_pulse_width = 16'd0;
    bus.I_delay       = 16'd7;
    bus.I_invert      = 1'b1;
    bus.I_sources     = 4'b0010;
    tick(2);
    rec = '0;
    for (int c = 0; c < 11; c++) begin
      bus.I_sources = (c < 7) ? 4'b0000 : 4'b0010;
      tick(1);
      rec[c] = bus.O_trig_out;
    end
    chk("c_level", rec, 32'h7F);
    chk("c_count", 32'(bus.O_trig_count), 32'd4);
    chk("c_busy",  32'(bus.O_busy),       32'd0);

    // Reset in the middle of a long pulse.
    bus.I_invert      = 1'b0;
    bus.I_sources     = 4'b0000;
    bus.I_pulse_width = 16'd8;
    bus.I_delay       = 16'd0;
    tick(2);
    bus.I_sources = 4'b0010;
    tick(2);
    chk("r_pre_trig", 32'(bus.O_trig_out), 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("r_trig",   32'(bus.O_trig_out),     32'd0);
    chk("r_dbg",    32'(bus.O_trig_out_dbg), 32'd0);
    chk("r_busy",   32'(bus.O_busy),         32'd0);
    chk("r_armed",  32'(bus.O_armed),        32'd0);
    chk("r_count",  32'(bus.O_trig_count),   32'd0);
    chk("r_missed", 32'(bus.O_missed_count), 32'd0);

    // Reselection 0 -> 2 with source 2 high must not trigger.
    bus.I_src_sel     = 2'd0;
    bus.I_sources     = 4'b0100;
    bus.I_continuous  = 1'b0;
    bus.I_pulse_width = 16'd3;
    rst_n = 1'b1;
    tick(1);
    bus.I_arm = 1'b1;
    tick(1);
    bus.I_arm = 1'b0;
    bus.I_src_sel = 2'd2;
    rec = '0; rec2 = '0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      rec[i]  = bus.O_trig_out;
      rec2[i] = bus.O_busy;
    end
    chk("d_resel_trig",  rec,  32'h0);
    chk("d_resel_busy",  rec2, 32'h0);
    chk("d_resel_armed", 32'(bus.O_armed), 32'd1);
    bus.I_sources = 4'b0000;
    tick(1);
    bus.I_sources = 4'b0100;
    rec = '0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      rec[i] = bus.O_trig_out;
    end
    chk("d_next_trig", rec, 32'h07);
    chk("d_oneshot",   32'(bus.O_armed),      32'd0);
    chk("d_count1",    32'(bus.O_trig_count), 32'd1);

    // Arm coincident with an edge: edge ignored, router armed afterwards.
    bus.I_sources = 4'b0000;
    tick(1);
    bus.I_arm     = 1'b1;
    bus.I_sources = 4'b0100;
    rec = '0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      bus.I_arm = 1'b0;
      rec[i] = bus.O_trig_out;
    end
    chk("d_armedge_trig",  rec, 32'h0);
    chk("d_armedge_armed", 32'(bus.O_armed), 32'd1);
    bus.I_sources = 4'b0000;
    tick(1);
    bus.I_sources = 4'b0100;
    rec = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      rec[i] = bus.O_trig_out;
    end
    chk("d_after_trig", rec, 32'h07);
    chk("d_count2",     32'(bus.O_trig_count), 32'd2);

    // Holdoff 4, continuous, width 3: edges at 0, 5 and 9.
    bus.I_continuous = 1'b1;
    bus.I_holdoff    = 16'd4;
    bus.I_sources    = 4'b0000;
    bus.I_arm        = 1'b1;
    tick(1);
    bus.I_arm = 1'b0;
    rec = '0; rec2 = '0;
    for (int c = 0; c < 10; c++) begin
      bus.I_sources = (c == 0 || c == 5 || c == 9) ? 4'b0100 : 4'b0000;
      tick(1);
      rec[c]  = bus.O_trig_out;
      rec2[c] = bus.O_busy;
    end
    bus.I_sources = 4'b0000;
    tick(12);
`ifdef TRIG_HOLDOFF_EN
    chk("h_busy",   rec2, 32'h27F);
    chk("h_trig",   rec,  32'h207);
    chk("h_missed", 32'(bus.O_missed_count), 32'd1);
    chk("h_count",  32'(bus.O_trig_count),   32'd4);
`else
    chk("h_busy",   rec2, 32'h2E7);
    chk("h_trig",   rec,  32'h2E7);
    chk("h_missed", 32'(bus.O_missed_count), 32'd0);
    chk("h_count",  32'(bus.O_trig_count),   32'd5);
`endif

    // Heartbeat freeze: a 5-cycle pulse delays the MSB rise from cycle 8 to 13.
    rst_n = 1'b0;
    tick(1);
    bus.I_src_sel     = 2'd1;
    bus.I_pulse_width = 16'd5;
    bus.I_delay       = 16'd0;
    bus.I_continuous  = 1'b0;
    bus.I_sources     = 4'b0000;
    bus.I_holdoff     = 16'd0;
    bus.I_invert      = 1'b0;
    rst_n     = 1'b1;
    bus.I_arm = 1'b1;
    first_led = -1;
    for (int c = 1; c <= 40; c++) begin
      tick(1);
      bus.I_arm = 1'b0;
      if (c == 1) bus.I_sources = 4'b0010;
      if (bus.O_led_alive && first_led < 0) first_led = c;
    end
    chk("hb_freeze",   32'(first_led), 32'd13);
    chk("hb_count",    32'(bus.O_trig_count), 32'd1);

    // Saturation: 17 accepted and 33 missed edges against 4-bit counters.
    bus.I_continuous  = 1'b1;
    bus.I_pulse_width = 16'd4;
    bus.I_sources     = 4'b0000;
    bus.I_arm         = 1'b1;
    tick(1);
    bus.I_arm = 1'b0;
    for (int c = 0; c < 100; c++) begin
      bus.I_sources = (c % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(1);
    end
    bus.I_sources = 4'b0000;
    tick(8);
    chk("sat_count",  32'(bus.O_trig_count),   32'd15);
    chk("sat_missed", 32'(bus.O_missed_count), 32'd15);

    // Arm strobe in the final pulse cycle of a one-shot keeps the router armed.
    bus.I_continuous  = 1'b0;
    bus.I_pulse_width = 16'd3;
    tick(1);
    bus.I_sources = 4'b0010;
    tick(3);
    bus.I_arm = 1'b1;
    tick(1);
    bus.I_arm = 1'b0;
    chk("aw_armed", 32'(bus.O_armed), 32'd1);
    chk("aw_busy",  32'(bus.O_busy),  32'd0);
    bus.I_sources = 4'b0000;
    tick(1);
    bus.I_sources = 4'b0010;
    tick(6);
    chk("aw_oneshot", 32'(bus.O_armed), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
